ps2_key_event_tracker: RTL and testbench
========================================

Name: ps2_key_event_tracker

Overview:
- Clocked successor to the inline PS/2 key-state decoder that feeds inputStateStorage.
- Consumes byte strobes from PS2_Controller and tracks make/break/extended (E0) sequences with an FSM.
- Maintains a parametrised held-key vector, emits press/release pulses, and queues key events in a FIFO for MasterFSM and mainStateHandler.
- Adds repeat suppression, prefix timeout, a held-key count and FIFO overflow reporting.

Parameters:
NUM_KEYS, 29, number of tracked keys (1..32); mapped indices >= NUM_KEYS are treated as unmapped.
FIFO_DEPTH, 8, event FIFO entries; power of two, 2..64.
TIMEOUT_CYCLES, 50000, cycles a prefix state waits for the next byte before returning to IDLE (1 ms at 50 MHz).

Ports:
CLOCK_50  in  1  system clock
resetn  in  1  asynchronous, active-low reset
rx_data  in  8  received PS/2 byte (recievedData)
rx_valid  in  1  one-cycle strobe that rx_data is new (recievedNewData)
clear_all  in  1  synchronous; clears key_state and held_count, no events generated
key_state  out  NUM_KEYS  1 = key held, bit = key index
key_press_pulse  out  1  one cycle, on an accepted make
key_release_pulse  out  1  one cycle, on an accepted break
held_count  out  6  number of set bits in key_state
evt_valid  out  1  FIFO non-empty
evt_data  out  6  head entry {make(1), index(5)}; make=1 press, 0 release
evt_ready  in  1  pop head when evt_valid & evt_ready
evt_overflow  out  1  sticky; set when an event was dropped on full
clear_overflow  in  1  synchronous clear of evt_overflow

Behaviour:
- Reset (resetn=0, async): FSM=IDLE, key_state=0, held_count=0, pulses=0, FIFO empty, evt_valid=0, evt_data=0, evt_overflow=0, timeout counter=0.
- Key map (combinational, unmapped -> miss): 0E→0, 16→1, 1E→2, 26→3, 25→4, 2E→5, 36→6, 3D→7, 3E→8, 46→9, 45→10, 4E→11, 55→12, 66→13, 0D→14, 15→15, 1D→16, 24→17, 2D→18, 2C→19, 35→20, 3C→21, 43→22, 44→23, 4D→24, 54→25, 5B→26, 5D→27, 29→28.
- FSM, advanced only on rx_valid:
  - IDLE: F0→BRK; E0→EXT; FA/AA/FE/EE/00/FF→stay, ignored; else make.
  - BRK: any non-prefix byte→break, then IDLE.
  - EXT: F0→EXT_BRK; else discard, then IDLE.
  - EXT_BRK: any byte is discarded, then IDLE.
  - All extended sequences are consumed without effect.
- Timeout: in BRK, EXT or EXT_BRK, the counter increments each cycle without rx_valid. At TIMEOUT_CYCLES it returns to IDLE with no effect. The counter clears on rx_valid and in IDLE.
- Make on mapped index i:
  - If key_state[i]=0: set bit, increment held_count, pulse key_press_pulse, push {1,i}.
  - If already set (typematic repeat): no change, no pulse, no event.
- Break on mapped index i:
  - If set: clear bit, decrement held_count, pulse key_release_pulse, push {0,i}.
  - If clear: ignored.
- Latency: rx_valid in cycle N → key_state, held_count and pulse in cycle N+1. evt_valid is high in N+1 if the FIFO was empty.
- FIFO: registered storage with read/write pointers and a count.
  - Simultaneous push and pop is allowed when non-empty, including when full; the count is unchanged.
  - Push when full and no pop: event dropped, evt_overflow set. key_state is still updated.
  - Pop when empty: ignored.
- Overflow: clear_overflow and a new drop in the same cycle leaves evt_overflow=1.
- clear_all: has priority over a same-cycle byte effect. The FSM returns to IDLE, the FIFO is preserved, and no pulses are generated.
- Mid-sequence reset: returns to IDLE; a following orphan make byte is treated as a fresh make.

Decomposition:
- Shared package/header (DefineMacros.vh style): key index constants (keyTilda…keySpacebar = 0..28), scancode constants (F0, E0, ignored codes), FSM state encodings, and event field offsets.
- Sub-module ps2_scancode_map: combinational byte → {hit, index[4:0]}. The FIFO is kept inline.

Test Plan:
- Bytes 15, F0, 15: press pulse; key_state[15]=1, held_count=1, event {1,15}; then release pulse; key_state[15]=0, event {0,15}.
- Bytes 1C,1C,1C (A, unmapped) then 29,29,29: no effect for 1C; a single press pulse and single event {1,28}; held_count=1.
- Bytes E0,75 then E0,F0,75 then 16: only 16 acts; key_state[1]=1, exactly one event.
- Byte F0, then 50001 idle cycles, then 16: timeout to IDLE; 16 treated as make; key_state[1]=1.
- FIFO_DEPTH=8, evt_ready=0, 9 distinct makes: 8 events queued; evt_overflow=1; key_state holds 9 bits; held_count=9. Then pop-and-push in the same cycle: count stays 8.
- resetn pulsed low asynchronously mid-EXT with keys held: all outputs 0 immediately; the next F0,16 is ignored because the key is not held.

Source files
------------

// File: rtl/ps2_key_event_tracker_pkg.sv
// ---------------------------------------------------------------------------
// ps2_key_event_tracker_pkg
// Shared definitions for the PS/2 key event tracker:
//   - key index constants (keyTilda .. keySpacebar = 0 .. 28)
//   - scancode constants (break/extended prefixes, ignored controller codes)
//   - FSM state encoding
//   - event word field layout {make, index}
// ---------------------------------------------------------------------------
package ps2_key_event_tracker_pkg;

  // Key indices, bit positions in key_state
  localparam int unsigned keyTilda     = 0;
  localparam int unsigned key1         = 1;
  localparam int unsigned key2         = 2;
  localparam int unsigned key3         = 3;
  localparam int unsigned key4         = 4;
  localparam int unsigned key5         = 5;
  localparam int unsigned key6         = 6;
  localparam int unsigned key7         = 7;
  localparam int unsigned key8         = 8;
  localparam int unsigned key9         = 9;
  localparam int unsigned key0         = 10;
  localparam int unsigned keyMinus     = 11;
  localparam int unsigned keyEquals    = 12;
  localparam int unsigned keyBackspace = 13;
  localparam int unsigned keyTab       = 14;
  localparam int unsigned keyQ         = 15;
  localparam int unsigned keyW         = 16;
  localparam int unsigned keyE         = 17;
  localparam int unsigned keyR         = 18;
  localparam int unsigned keyT         = 19;
  localparam int unsigned keyY         = 20;
  localparam int unsigned keyU         = 21;
  localparam int unsigned keyI         = 22;
  localparam int unsigned keyO         = 23;
  localparam int unsigned keyP         = 24;
  localparam int unsigned keyLBracket  = 25;
  localparam int unsigned keyRBracket  = 26;
  localparam int unsigned keyBackslash = 27;
  localparam int unsigned keySpacebar  = 28;

  // Scancodes
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_BAT_OK = 8'hAA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_ERR_LO = 8'h00;
  localparam logic [7:0] SC_ERR_HI = 8'hFF;

  // Tracker FSM
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } kt_state_e;

  // Event word layout
  localparam int unsigned IDX_W        = 5;
  localparam int unsigned EVT_W        = 6;
  localparam int unsigned EVT_MAKE_BIT = 5;

  // Controller/status bytes that never start a key sequence
  function automatic logic is_ignored_code(input logic [7:0] code);
    return (code == SC_ACK) || (code == SC_BAT_OK) || (code == SC_RESEND) ||
           (code == SC_ECHO) || (code == SC_ERR_LO) || (code == SC_ERR_HI);
  endfunction

endpackage

// File: rtl/ps2_key_event_tracker_if.sv
// ---------------------------------------------------------------------------
// ps2_key_event_tracker_if
// Valid/ready key event stream leaving the tracker.
//   evt_valid : head entry present
//   evt_data  : head entry {make, index[4:0]}
//   evt_ready : consumer pops head when evt_valid & evt_ready
// master = tracker (producer), slave = consumer.
// ---------------------------------------------------------------------------
interface ps2_key_event_tracker_if;
  import ps2_key_event_tracker_pkg::*;

  logic             evt_valid;
  logic [EVT_W-1:0] evt_data;
  logic             evt_ready;

  modport master (output evt_valid, output evt_data, input evt_ready);
  modport slave  (input evt_valid, input evt_data, output evt_ready);
endinterface

// File: rtl/ps2_scancode_map.sv
// ---------------------------------------------------------------------------
// ps2_scancode_map
// Combinational scancode -> key index lookup.
//   i_code  : received PS/2 byte
//   o_hit   : byte maps to a tracked key (index < NUM_KEYS)
//   o_index : key index (valid only when o_hit)
// ---------------------------------------------------------------------------
module ps2_scancode_map
  import ps2_key_event_tracker_pkg::*;
#(
  parameter int unsigned NUM_KEYS = 29
) (
  input  logic [7:0]       i_code,
  output logic             o_hit,
  output logic [IDX_W-1:0] o_index
);

  logic             w_known;
  logic [IDX_W-1:0] w_idx;

  always_comb begin
    w_known = 1'b1;
    w_idx   = '0;
    case (i_code)
      8'h0E:   w_idx = IDX_W'(keyTilda);
      8'h16:   w_idx = IDX_W'(key1);
      8'h1E:   w_idx = IDX_W'(key2);
      8'h26:   w_idx = IDX_W'(key3);
      8'h25:   w_idx = IDX_W'(key4);
      8'h2E:   w_idx = IDX_W'(key5);
      8'h36:   w_idx = IDX_W'(key6);
      8'h3D:   w_idx = IDX_W'(key7);
      8'h3E:   w_idx = IDX_W'(key8);
      8'h46:   w_idx = IDX_W'(key9);
      8'h45:   w_idx = IDX_W'(key0);
      8'h4E:   w_idx = IDX_W'(keyMinus);
      8'h55:   w_idx = IDX_W'(keyEquals);
      8'h66:   w_idx = IDX_W'(keyBackspace);
      8'h0D:   w_idx = IDX_W'(keyTab);
      8'h15:   w_idx = IDX_W'(keyQ);
      8'h1D:   w_idx = IDX_W'(keyW);
      8'h24:   w_idx = IDX_W'(keyE);
      8'h2D:   w_idx = IDX_W'(keyR);
      8'h2C:   w_idx = IDX_W'(keyT);
      8'h35:   w_idx = IDX_W'(keyY);
      8'h3C:   w_idx = IDX_W'(keyU);
      8'h43:   w_idx = IDX_W'(keyI);
      8'h44:   w_idx = IDX_W'(keyO);
      8'h4D:   w_idx = IDX_W'(keyP);
      8'h54:   w_idx = IDX_W'(keyLBracket);
      8'h5B:   w_idx = IDX_W'(keyRBracket);
      8'h5D:   w_idx = IDX_W'(keyBackslash);
      8'h29:   w_idx = IDX_W'(keySpacebar);
      default: w_known = 1'b0;
    endcase
  end

  // Indices beyond the configured key count behave as unmapped
  assign o_hit   = w_known && (32'(w_idx) < NUM_KEYS);
  assign o_index = w_idx;

endmodule

// File: rtl/ps2_key_event_tracker.sv
// ---------------------------------------------------------------------------
// ps2_key_event_tracker
// Tracks PS/2 make/break/E0 sequences, keeps a held-key vector and count,
// emits one-cycle press/release pulses and queues {make,index} events.
//   CLOCK_50, resetn     : clock, async active-low reset
//   rx_data, rx_valid    : received byte and its one-cycle strobe
//   clear_all            : drop all held keys (no events)
//   key_state, held_count: held-key vector and its population count
//   key_press_pulse / key_release_pulse : accepted make / break
//   evt (master)         : event FIFO head, valid/ready
//   evt_overflow         : sticky drop flag, cleared by clear_overflow
// ---------------------------------------------------------------------------
module ps2_key_event_tracker
  import ps2_key_event_tracker_pkg::*;
#(
  parameter int unsigned NUM_KEYS       = 29,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                    CLOCK_50,
  input  logic                    resetn,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  input  logic                    clear_all,
  output logic [NUM_KEYS-1:0]     key_state,
  output logic                    key_press_pulse,
  output logic                    key_release_pulse,
  output logic [5:0]              held_count,
  ps2_key_event_tracker_if.master evt,
  output logic                    evt_overflow,
  input  logic                    clear_overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  kt_state_e           r_state, w_next_state;
  logic [TW-1:0]       r_timer;
  logic [NUM_KEYS-1:0] r_key_state;
  logic [5:0]          r_held_count;
  logic                r_press, r_release;

  logic                w_hit;
  logic [IDX_W-1:0]    w_index;
  logic                w_make, w_break, w_held, w_press, w_release, w_push;
  logic [31:0]         w_keys32;
  logic [NUM_KEYS-1:0] w_mask;
  logic [EVT_W-1:0]    w_push_data;

  logic [EVT_W-1:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wptr, r_rptr;
  logic [AW:0]         r_count;
  logic                r_overflow;
  logic                w_empty, w_full, w_pop, w_wr, w_drop;

  ps2_scancode_map #(.NUM_KEYS(NUM_KEYS)) u_map (
    .i_code  (rx_data),
    .o_hit   (w_hit),
    .o_index (w_index)
  );

  // Sequence decode: next state plus whether this byte completes a make/break
  always_comb begin
    w_next_state = r_state;
    w_make       = 1'b0;
    w_break      = 1'b0;
    if (rx_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (rx_data == SC_BREAK)       w_next_state = ST_BRK;
          else if (rx_data == SC_EXT)    w_next_state = ST_EXT;
          else if (!is_ignored_code(rx_data)) w_make = w_hit;
        end
        ST_BRK: begin
          if (rx_data == SC_BREAK)       w_next_state = ST_BRK;
          else if (rx_data == SC_EXT)    w_next_state = ST_EXT;
          else begin
            w_break      = w_hit;
            w_next_state = ST_IDLE;
          end
        end
        ST_EXT: begin
          if (rx_data == SC_BREAK)       w_next_state = ST_EXT_BRK;
          else                           w_next_state = ST_IDLE;
        end
        default:                         w_next_state = ST_IDLE;
      endcase
    end else if (r_state != ST_IDLE && r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
      w_next_state = ST_IDLE;
    end
  end

  // Typematic repeats and breaks of unheld keys fall out of the held test
  assign w_keys32  = 32'(r_key_state);
  assign w_held    = w_keys32[w_index];
  assign w_press   = w_make  & ~w_held & ~clear_all;
  assign w_release = w_break &  w_held & ~clear_all;
  assign w_push    = w_press | w_release;
  assign w_mask    = NUM_KEYS'(1) << w_index;

  always_comb begin
    w_push_data               = '0;
    w_push_data[EVT_MAKE_BIT] = w_press;
    w_push_data[IDX_W-1:0]    = w_index;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_timer      <= '0;
      r_key_state  <= '0;
      r_held_count <= '0;
      r_press      <= 1'b0;
      r_release    <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      if (clear_all) begin
        r_state      <= ST_IDLE;
        r_timer      <= '0;
        r_key_state  <= '0;
        r_held_count <= '0;
      end else begin
        r_state <= w_next_state;
        if (rx_valid || w_next_state == ST_IDLE) r_timer <= '0;
        else                                     r_timer <= r_timer + TW'(1);
        if (w_press) begin
          r_key_state  <= r_key_state | w_mask;
          r_held_count <= r_held_count + 6'd1;
          r_press      <= 1'b1;
        end else if (w_release) begin
          r_key_state  <= r_key_state & ~w_mask;
          r_held_count <= r_held_count - 6'd1;
          r_release    <= 1'b1;
        end
      end
    end
  end

  // Event FIFO; a pop frees the slot a same-cycle push needs when full
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_pop   = ~w_empty & evt.evt_ready;
  assign w_wr    = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop)              r_overflow <= 1'b1;
      else if (clear_overflow) r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (w_wr) r_mem[r_wptr] <= w_push_data;
  end

  assign key_state         = r_key_state;
  assign held_count        = r_held_count;
  assign key_press_pulse   = r_press;
  assign key_release_pulse = r_release;
  assign evt_overflow      = r_overflow;
  assign evt.evt_valid     = ~w_empty;
  assign evt.evt_data      = w_empty ? '0 : r_mem[r_rptr];

endmodule

// File: tb/tb_ps2_key_event_tracker.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_event_tracker
// Directed scenarios with literal expectations, then randomized byte traffic,
// all compared every cycle against a behavioural model (pending-prefix byte
// queue, key bit array, event queue).
// ---------------------------------------------------------------------------
module tb_ps2_key_event_tracker;
  localparam int unsigned NK = 29;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TO = 40;

  logic          CLOCK_50 = 1'b0;
  logic          resetn = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          clear_all = 1'b0;
  logic          clear_overflow = 1'b0;
  logic [NK-1:0] key_state;
  logic          key_press_pulse, key_release_pulse;
  logic [5:0]    held_count;
  logic          evt_overflow;

  ps2_key_event_tracker_if evt_if();

  ps2_key_event_tracker #(.NUM_KEYS(NK), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_50          (CLOCK_50),
    .resetn            (resetn),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .clear_all         (clear_all),
    .key_state         (key_state),
    .key_press_pulse   (key_press_pulse),
    .key_release_pulse (key_release_pulse),
    .held_count        (held_count),
    .evt               (evt_if.master),
    .evt_overflow      (evt_overflow),
    .clear_overflow    (clear_overflow)
  );

  initial forever #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  byte unsigned codes [29] = '{8'h0E, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                               8'h3E, 8'h46, 8'h45, 8'h4E, 8'h55, 8'h66, 8'h0D, 8'h15,
                               8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44,
                               8'h4D, 8'h54, 8'h5B, 8'h5D, 8'h29};
  int            map_tbl [256];
  logic [NK-1:0] m_keys = '0;
  bit            m_press = 1'b0, m_release = 1'b0, m_ovf = 1'b0;
  byte unsigned  pend [$];   // prefix bytes of the sequence in progress
  int            age = 0;    // idle cycles since the last prefix byte
  logic [5:0]    mq [$];

  function automatic bit is_ign(input byte unsigned d);
    return d inside {8'hFA, 8'hAA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
  endfunction

  task automatic model_reset();
    m_keys = '0; m_press = 0; m_release = 0; m_ovf = 0;
    pend.delete(); age = 0; mq.delete();
  endtask

  task automatic model_step();
    bit pop, push, drop;
    int idx;
    byte unsigned d;
    logic [5:0] pdata;
    pop = (mq.size() != 0) && evt_if.evt_ready;
    push = 0; drop = 0; pdata = '0;
    m_press = 0; m_release = 0;
    d = rx_data;
    idx = map_tbl[d];
    if (clear_all) begin
      m_keys = '0; pend.delete(); age = 0;
    end else if (rx_valid) begin
      age = 0;
      if (pend.size() == 0) begin
        if (d == 8'hF0 || d == 8'hE0) pend.push_back(d);
        else if (!is_ign(d) && idx >= 0 && !m_keys[idx]) begin
          m_keys[idx] = 1'b1; m_press = 1; push = 1; pdata = {1'b1, 5'(idx)};
        end
      end else if (pend[0] == 8'hF0) begin
        if (d == 8'hE0) begin pend.delete(); pend.push_back(d); end
        else if (d != 8'hF0) begin
          pend.delete();
          if (idx >= 0 && m_keys[idx]) begin
            m_keys[idx] = 1'b0; m_release = 1; push = 1; pdata = {1'b0, 5'(idx)};
          end
        end
      end else if (pend.size() == 1) begin
        if (d == 8'hF0) pend.push_back(d); else pend.delete();
      end else begin
        pend.delete();
      end
    end else if (pend.size() != 0) begin
      age++;
      if (age >= TO) begin pend.delete(); age = 0; end
    end
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(pdata); else drop = 1;
    end
    if (drop) m_ovf = 1;
    else if (clear_overflow) m_ovf = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) map_tbl[i] = -1;
    for (int i = 0; i < 29; i++) if (i < NK) map_tbl[codes[i]] = i;
    forever begin
      @(posedge CLOCK_50 or negedge resetn);
      if (!resetn) model_reset(); else model_step();
    end
  end

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge CLOCK_50);
    chk("key_state", key_state, m_keys);
    chk("held_count", held_count, $countones(m_keys));
    chk("press_pulse", key_press_pulse, m_press);
    chk("release_pulse", key_release_pulse, m_release);
    chk("evt_valid", evt_if.evt_valid, mq.size() != 0);
    chk("evt_data", evt_if.evt_data, (mq.size() != 0) ? mq[0] : 6'd0);
    chk("evt_overflow", evt_overflow, m_ovf);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got running, want finished");
    $fatal(1);
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic send(input byte unsigned b);
    rx_data = b; rx_valid = 1'b1;
    @(negedge CLOCK_50);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic clr();
    clear_all = 1'b1;
    @(negedge CLOCK_50);
    clear_all = 1'b0;
  endtask

  task automatic drain(output int n);
    n = 0;
    evt_if.evt_ready = 1'b1;
    for (int i = 0; i < int'(DEPTH) + 4; i++) begin
      if (!evt_if.evt_valid) break;
      n++;
      @(negedge CLOCK_50);
    end
    evt_if.evt_ready = 1'b0;
    chk("drain_empty", evt_if.evt_valid, 0);
  endtask

  function automatic byte unsigned pick();
    int r = $urandom_range(0, 99);
    byte unsigned ign [6] = '{8'hFA, 8'hAA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
    if (r < 50) return codes[$urandom_range(0, 28)];
    if (r < 70) return 8'hF0;
    if (r < 80) return 8'hE0;
    if (r < 85) return ign[$urandom_range(0, 5)];
    return 8'($urandom_range(0, 255));
  endfunction

  int n;

  initial begin
    evt_if.evt_ready = 1'b0;
    idle(3);
    chk("rst_key_state", key_state, 0);
    chk("rst_held", held_count, 0);
    chk("rst_evt_valid", evt_if.evt_valid, 0);
    chk("rst_evt_data", evt_if.evt_data, 0);
    chk("rst_ovf", evt_overflow, 0);
    resetn = 1'b1;
    idle(2);

    // Q press then release
    send(8'h15);
    chk("q_press", key_press_pulse, 1);
    chk("q_state", key_state, 32'h0000_8000);
    chk("q_held", held_count, 1);
    chk("q_evt", evt_if.evt_data, 6'h2F);
    send(8'hF0);
    chk("q_prefix_nochg", key_state, 32'h0000_8000);
    send(8'h15);
    chk("q_release", key_release_pulse, 1);
    chk("q_state_rel", key_state, 0);
    chk("q_held_rel", held_count, 0);
    evt_if.evt_ready = 1'b1;
    @(negedge CLOCK_50);
    evt_if.evt_ready = 1'b0;
    chk("q_evt_rel", evt_if.evt_data, 6'h0F);
    drain(n);
    chk("q_evt_count", n, 1);

    // Unmapped repeats, then spacebar typematic repeat
    send(8'h1C); send(8'h1C); send(8'h1C);
    chk("a_state", key_state, 0);
    chk("a_evt_valid", evt_if.evt_valid, 0);
    send(8'h29);
    chk("sp_press", key_press_pulse, 1);
    send(8'h29);
    chk("sp_repeat_nopulse", key_press_pulse, 0);
    send(8'h29);
    chk("sp_state", key_state, 32'h1000_0000);
    chk("sp_held", held_count, 1);
    chk("sp_evt", evt_if.evt_data, 6'h3C);
    drain(n);
    chk("sp_evt_count", n, 1);

    // Extended sequences are swallowed
    clr();
    chk("clr_held", held_count, 0);
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    chk("ext_state", key_state, 0);
    chk("ext_evt_valid", evt_if.evt_valid, 0);
    send(8'h16);
    chk("ext_then_1", key_state, 32'h2);
    chk("ext_then_1_evt", evt_if.evt_data, 6'h21);
    drain(n);
    chk("ext_evt_count", n, 1);

    // Prefix timeout boundaries
    clr();
    send(8'hF0); idle(TO + 1); send(8'h16);
    chk("to_long_make", key_state, 32'h2);
    send(8'hF0); idle(TO - 1); send(8'h16);
    chk("to_short_break", key_release_pulse, 1);
    chk("to_short_state", key_state, 0);
    send(8'hF0); idle(TO); send(8'h16);
    chk("to_exact_make", key_press_pulse, 1);
    chk("to_exact_state", key_state, 32'h2);
    drain(n);
    chk("to_evt_count", n, 3);

    // FIFO overflow, then pop and push together while full
    clr();
    clear_overflow = 1'b1; @(negedge CLOCK_50); clear_overflow = 1'b0;
    for (int i = 0; i < 9; i++) send(codes[i]);
    chk("ovf_flag", evt_overflow, 1);
    chk("ovf_held", held_count, 9);
    chk("ovf_state", key_state, 32'h1FF);
    chk("ovf_head", evt_if.evt_data, 6'h20);
    evt_if.evt_ready = 1'b1;
    send(8'h46);
    evt_if.evt_ready = 1'b0;
    chk("pp_held", held_count, 10);
    chk("pp_head", evt_if.evt_data, 6'h21);
    chk("pp_ovf_kept", evt_overflow, 1);
    drain(n);
    chk("pp_count", n, 8);
    clear_overflow = 1'b1; @(negedge CLOCK_50); clear_overflow = 1'b0;
    chk("ovf_cleared", evt_overflow, 0);

    // Asynchronous reset in the middle of an extended sequence
    clr();
    send(8'h16); send(8'h1E); send(8'hE0);
    #3 resetn = 1'b0;
    #1;
    chk("ar_state", key_state, 0);
    chk("ar_held", held_count, 0);
    chk("ar_evt_valid", evt_if.evt_valid, 0);
    chk("ar_evt_data", evt_if.evt_data, 0);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    send(8'hF0); send(8'h16);
    chk("ar_no_release", key_release_pulse, 0);
    chk("ar_state_after", key_state, 0);
    chk("ar_no_evt", evt_if.evt_valid, 0);

    // Randomized traffic
    for (int it = 0; it < 4000; it++) begin
      evt_if.evt_ready = ($urandom_range(0, 99) < 45);
      clear_all        = ($urandom_range(0, 199) == 0);
      clear_overflow   = ($urandom_range(0, 49) == 0);
      resetn           = ($urandom_range(0, 799) != 0);
      if ($urandom_range(0, 99) < 35) begin
        rx_valid = 1'b1;
        rx_data  = pick();
      end else begin
        rx_valid = 1'b0;
      end
      @(negedge CLOCK_50);
      if ($urandom_range(0, 99) < 2) begin
        rx_valid = 1'b0; clear_all = 1'b0; resetn = 1'b1;
        idle($urandom_range(TO - 2, TO + 2));
      end
    end
    resetn = 1'b1; rx_valid = 1'b0; clear_all = 1'b0; clear_overflow = 1'b0;
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
